fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: instruction width, NOP encoding,
// fetch FSM states and the IF/ID payload.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } if_id_t;

   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush or when
// nothing is delivered; flush beats stall.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   stall,
   input  logic   flush,
   input  logic   load,
   input  if_id_t entry,
   output if_id_t ifid,
   output logic   valid
);

   // A bubble only replaces the instruction word; PCs keep their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid.instr    <= NOP_INSTR;
         ifid.pc       <= '0;
         ifid.pc_plus4 <= '0;
         valid         <= 1'b0;
      end else if (flush || (!stall && !load)) begin
         ifid.instr <= NOP_INSTR;
         valid      <= 1'b0;
      end else if (!stall) begin
         ifid  <= entry;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request/grant/response fetch
// with stall buffering, redirect handling and an IF/ID register.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   fetch_state_t state;
   logic [31:0]  hold_buf;
   logic         deliver;
   if_id_t       entry;
   if_id_t       ifid;

   // A redirect in the same cycle cancels any delivery.
   assign deliver = !PCSrcE && !StallD &&
                    (((state == S_WAIT) && imem_rvalid) || (state == S_HOLD));

   assign entry.instr    = (state == S_HOLD) ? hold_buf : imem_rdata;
   assign entry.pc       = PCF;
   assign entry.pc_plus4 = pc_plus4(PCF);

   // No request is presented while reset is held, so nothing can be granted.
   assign imem_req  = (state == S_REQ) && !rst;
   assign imem_addr = PCF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_REQ;
         PCF      <= RESET_PC;
         hold_buf <= '0;
      end else begin
         if (PCSrcE) begin
            PCF <= PCTargetE;
         end else if (deliver) begin
            PCF <= pc_plus4(PCF);
         end

         case (state)
            S_REQ: begin
               if (imem_gnt) begin
                  state <= PCSrcE ? S_DROP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (PCSrcE) begin
                  state <= imem_rvalid ? S_REQ : S_DROP;
               end else if (imem_rvalid) begin
                  if (StallD) begin
                     state    <= S_HOLD;
                     hold_buf <= imem_rdata;
                  end else begin
                     state <= S_REQ;
                  end
               end
            end
            S_HOLD: begin
               if (PCSrcE || !StallD) begin
                  state <= S_REQ;
               end
            end
            S_DROP: begin
               // The stale old-PC response is swallowed here.
               if (imem_rvalid) begin
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .rst   (rst),
      .stall (StallD),
      .flush (FlushD),
      .load  (deliver),
      .entry (entry),
      .ifid  (ifid),
      .valid (ValidD)
   );

   assign InstrD   = ifid.instr;
   assign PCD      = ifid.pc;
   assign PCPlus4D = ifid.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: drives the memory handshake cycle by cycle
// and compares outputs against hand-derived values.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int n_vec;
   int n_err;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .PCF         (PCF),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .ValidD      (ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory content: a recognisable word per address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One unstalled fetch: grant, gap cycle, response, delivery.
   task automatic fetch_one(input logic [31:0] a);
      logic [31:0] nxt;
      nxt = a + 32'd4;
      check("req_high", imem_req, 1);
      check("req_addr", imem_addr, a);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      check("gap_req_low", imem_req, 0);
      check("gap_valid", ValidD, 0);
      check("gap_instr", InstrD, NOP);
      imem_rvalid = 1'b1;
      imem_rdata  = mem(a);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      check("dlv_instr", InstrD, mem(a));
      check("dlv_valid", ValidD, 1);
      check("dlv_pcd", PCD, a);
      check("dlv_pcp4", PCPlus4D, nxt);
      check("dlv_pcf", PCF, nxt);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      StallD = 1'b0;
      FlushD = 1'b0;
      PCSrcE = 1'b0;
      PCTargetE = '0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;

      #12;
      check("rst_pcf", PCF, 32'h0);
      check("rst_instr", InstrD, NOP);
      check("rst_valid", ValidD, 0);
      check("rst_pcd", PCD, 0);
      check("rst_pcp4", PCPlus4D, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_req", imem_req, 1);

      // Back-to-back fetches from 0
      fetch_one(32'h0);
      fetch_one(32'h4);
      fetch_one(32'h8);

      // Stall while holding mem(8); response for 12 buffered for 3 stall cycles
      StallD = 1'b1;
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      check("stl1_instr", InstrD, mem(32'h8));
      check("stl1_valid", ValidD, 1);
      imem_rvalid = 1'b1;
      imem_rdata  = mem(32'hC);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      check("stl2_instr", InstrD, mem(32'h8));
      check("stl2_pcd", PCD, 32'h8);
      check("stl2_pcf", PCF, 32'hC);
      check("stl2_req", imem_req, 0);
      tick();
      check("stl3_instr", InstrD, mem(32'h8));
      check("stl3_pcf", PCF, 32'hC);
      StallD = 1'b0;
      tick();
      check("unstl_instr", InstrD, mem(32'hC));
      check("unstl_valid", ValidD, 1);
      check("unstl_pcd", PCD, 32'hC);
      check("unstl_pcf", PCF, 32'h10);
      check("unstl_req", imem_req, 1);

      // Redirect while in WAIT; response two cycles later is dropped
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      PCSrcE = 1'b1;
      PCTargetE = 32'h100;
      tick();
      PCSrcE = 1'b0;
      check("rdw_pcf", PCF, 32'h100);
      check("rdw_req", imem_req, 0);
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = mem(32'h10);
      tick();
      imem_rvalid = 1'b0;
      check("drop_valid", ValidD, 0);
      check("drop_instr", InstrD, NOP);
      check("drop_req", imem_req, 1);
      check("drop_addr", imem_addr, 32'h100);

      // Redirect and response in the same WAIT cycle; target wraps
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      PCSrcE = 1'b1;
      PCTargetE = 32'hFFFF_FFFC;
      imem_rvalid = 1'b1;
      imem_rdata  = mem(32'h100);
      tick();
      PCSrcE = 1'b0;
      imem_rvalid = 1'b0;
      check("same_valid", ValidD, 0);
      check("same_req", imem_req, 1);
      check("same_addr", imem_addr, 32'hFFFF_FFFC);
      fetch_one(32'hFFFF_FFFC);

      // Redirect in REQ without grant: new address next cycle
      PCSrcE = 1'b1;
      PCTargetE = 32'h200;
      tick();
      PCSrcE = 1'b0;
      check("rdr_req", imem_req, 1);
      check("rdr_addr", imem_addr, 32'h200);

      // Redirect with grant -> DROP; second redirect in DROP
      PCSrcE = 1'b1;
      PCTargetE = 32'h300;
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      PCTargetE = 32'h304;
      check("rdg_req", imem_req, 0);
      tick();
      PCSrcE = 1'b0;
      check("rdd_pcf", PCF, 32'h304);
      check("rdd_req", imem_req, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = mem(32'h200);
      tick();
      imem_rvalid = 1'b0;
      check("rdd_valid", ValidD, 0);
      check("rdd_addr", imem_addr, 32'h304);
      fetch_one(32'h304);

      // Flush beats stall
      FlushD = 1'b1;
      StallD = 1'b1;
      tick();
      FlushD = 1'b0;
      StallD = 1'b0;
      check("flush_instr", InstrD, NOP);
      check("flush_valid", ValidD, 0);
      check("flush_pcd", PCD, 32'h304);

      // Async reset while in WAIT
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      check("pre_rst_req", imem_req, 0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_pcf", PCF, 32'h0);
      check("arst_instr", InstrD, NOP);
      check("arst_valid", ValidD, 0);
      check("arst_pcd", PCD, 0);
      check("arst_pcp4", PCPlus4D, 0);
      #2;
      rst = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = mem(32'h308);
      tick();
      imem_rvalid = 1'b0;
      check("late_rsp_valid", ValidD, 0);
      check("late_rsp_req", imem_req, 1);
      check("late_rsp_addr", imem_addr, 32'h0);
      fetch_one(32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
